// File: rtl/alu_serial_seq_if.sv
// Operand/op request channel and result/flag response channel of alu_serial_seq.
interface alu_serial_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero, overflow
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero, overflow
    );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one bit per clock, LSB first, through a 1-bit slice with registered carry.
// Optional signed-overflow flag enabled by defining ALU_OVERFLOW_EN.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    alu_serial_seq_if.slave bus
);
    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_XOR, OP_NAND} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             carry_reg_q, carry_reg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             last_bit;
    logic             arith;
    logic             b_bit;
    logic             cout;
    logic             slice_bit;
    logic [WIDTH-1:0] final_res;

    assign last_bit = (cnt_q == CNTW'(WIDTH - 1));

    // 1-bit ALU slice; SUB feeds the inverted b bit and relies on carry_reg preset to 1.
    always_comb begin
        arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        b_bit = (op_q == OP_SUB) ? ~b_sh_q[0] : b_sh_q[0];
        cout  = (a_sh_q[0] & b_bit) | (a_sh_q[0] & carry_reg_q) | (b_bit & carry_reg_q);
        case (op_q)
            OP_ADD, OP_SUB: slice_bit = a_sh_q[0] ^ b_bit ^ carry_reg_q;
            OP_XOR:         slice_bit = a_sh_q[0] ^ b_sh_q[0];
            OP_NAND:        slice_bit = ~(a_sh_q[0] & b_sh_q[0]);
            default:        slice_bit = 1'b0;
        endcase
        final_res = {slice_bit, res_sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        cnt_d       = cnt_q;
        carry_reg_d = carry_reg_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d        = op_e'(bus.op);
                    a_sh_d      = bus.a;
                    b_sh_d      = bus.b;
                    res_sh_d    = '0;
                    cnt_d       = '0;
                    carry_reg_d = (op_e'(bus.op) == OP_SUB);
                end
            end
            SHIFT: begin
                a_sh_d      = a_sh_q >> 1;
                b_sh_d      = b_sh_q >> 1;
                res_sh_d    = final_res;
                cnt_d       = cnt_q + CNTW'(1);
                carry_reg_d = arith & cout;
                if (last_bit) begin
                    result_d = final_res;
                    carry_d  = arith & cout;
                    zero_d   = (final_res == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_ADD;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            cnt_q       <= '0;
            carry_reg_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            op_q        <= op_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            cnt_q       <= cnt_d;
            carry_reg_q <= carry_reg_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.carry     = carry_q;
        bus.zero      = zero_q;
    end

`ifdef ALU_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // On the MSB edge carry_reg_q is the carry into the MSB and cout the carry out.
    always_comb begin
        overflow_d = overflow_q;
        if (state_q == SHIFT && last_bit) begin
            overflow_d = arith & (carry_reg_q ^ cout);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized scoreboard bench for alu_serial_seq (WIDTH=8) with directed corner cases.
module tb_alu_serial_seq;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    alu_serial_seq_if #(.WIDTH(W)) bus ();

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ua = 32'(a);
        int unsigned ub = 32'(b);
        exp_t e;
        logic v;
        e.r = '0;
        e.c = 1'b0;
        v   = 1'b0;
        case (op)
            2'd0: begin
                e.r = W'(ua + ub);
                e.c = (ua + ub) >= 32'(1 << W);
                v   = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            2'd1: begin
                e.r = W'(ua - ub);
                e.c = (ua >= ub);
                v   = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            2'd2: e.r = a ^ b;
            default: e.r = ~(a & b);
        endcase
        e.z = (e.r == '0);
`ifdef ALU_OVERFLOW_EN
        e.v = v;
`else
        e.v = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // Monitor: a handshake occurs at the next posedge whenever both are high mid-cycle.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                timeout("unexpected_result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",   32'(bus.result),   32'(e.r));
                chk("carry",    32'(bus.carry),    32'(e.c));
                chk("zero",     32'(bus.zero),     32'(e.z));
                chk("overflow", 32'(bus.overflow), 32'(e.v));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int acc_cyc);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) timeout("accept_wait");
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        sb.push_back(model(op, a, b));
        tick();
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.out_valid && n < 4 * W) begin
            tick();
            n++;
        end
        if (!bus.out_valid) timeout(name);
        else chk(name, 32'(n), 32'(W));
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_result"},    32'(bus.result),    32'd0);
        chk({tag, "_carry"},     32'(bus.carry),     32'd0);
        chk({tag, "_zero"},      32'(bus.zero),      32'd0);
        chk({tag, "_overflow"},  32'(bus.overflow),  32'd0);
    endtask

    initial begin
        logic [1:0]   d_op[5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        logic [W-1:0] d_a[5]  = '{8'h7F, 8'h05, 8'h00, 8'hA5, 8'hF0};
        logic [W-1:0] d_b[5]  = '{8'h01, 8'h05, 8'h01, 8'hFF, 8'h3C};
        logic [W-1:0] held;
        int acc;
        int prev;
        int n;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check_idle_reset("rst");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            issue(d_op[i], d_a[i], d_b[i], acc);
            chk("shift_in_ready", 32'(bus.in_ready), 32'd0);
            wait_done("latency");
            tick();
            chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        end

        // Back-pressure: DONE must hold and ignore in_valid.
        bus.out_ready = 1'b0;
        issue(2'd0, 8'h12, 8'h34, acc);
        wait_done("bp_latency");
        held = bus.result;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            tick();
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_result",    32'(bus.result),    32'(held));
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("release_in_ready",  32'(bus.in_ready),  32'd1);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);

        // Abort mid-operation with reset.
        issue(2'd0, 8'hFF, 8'h01, acc);
        repeat (4) tick();
        reset = 1'b1;
        void'(sb.pop_back());
        tick();
        check_idle_reset("abort");
        reset = 1'b0;
        issue(2'd0, 8'h03, 8'h04, acc);
        wait_done("post_abort_latency");
        tick();

        // Back-to-back random traffic.
        prev = 0;
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   r_op = 2'($urandom);
            logic [W-1:0] r_a  = W'($urandom);
            logic [W-1:0] r_b  = ($urandom_range(7) == 0) ? r_a : W'($urandom);
            issue(r_op, r_a, r_b, acc);
            if (i > 0) chk("accept_spacing", 32'(acc - prev), 32'(W + 2));
            prev = acc;
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
